// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad one column at a time. Row
// inputs are synchronised and debounced over whole frames, and each accepted
// press is queued as a 4-bit code (col*4 + row) in a 2-entry valid/ack FIFO.
module keypad_scanner #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_FRAMES = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ack,
    output logic       overflow
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    logic [3:0]    row_s1, row_s2;
    logic [SW-1:0] slot;
    logic [1:0]    col;
    logic          sample;
    logic          frame_end;
    logic          frame_any;
    logic [3:0]    frame_code;
    logic [1:0]    low_row;
    logic          col_hit;

    state_t        state, state_n;
    logic [3:0]    cand, cand_n;
    logic [3:0]    cnt, cnt_n;
    logic [3:0]    cnt_inc;
    logic          push;

    logic [1:0]    fcnt;
    logic [3:0]    ent1;
    logic          pop;

    // Two-flop synchroniser for the asynchronous row lines (idle = all high).
    always_ff @(posedge Clock) begin
        if (Reset) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= row_n;
            row_s2 <= row_s1;
        end
    end

    // Rows are sampled in the last cycle of a slot so the column drive has settled.
    assign sample  = (slot == SW'(SCAN_DIV - 1));
    assign col_hit = (row_s2 != 4'hF);

    // Lowest pressed row in the currently driven column.
    always_comb begin
        low_row = 2'd3;
        if (!row_s2[0])      low_row = 2'd0;
        else if (!row_s2[1]) low_row = 2'd1;
        else if (!row_s2[2]) low_row = 2'd2;
    end

    // Slot and column counters; col_n is kept as its own register so it is glitch-free.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            slot  <= '0;
            col   <= 2'd0;
            col_n <= 4'b1110;
        end else if (sample) begin
            slot  <= '0;
            col   <= col + 2'd1;
            col_n <= ~(4'b0001 << (col + 2'd1));
        end else begin
            slot <= slot + SW'(1);
        end
    end

    // Frame record: first hit wins, since columns are visited in ascending order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            frame_end  <= 1'b0;
            frame_any  <= 1'b0;
            frame_code <= 4'h0;
        end else begin
            frame_end <= sample && (col == 2'd3);
            if (frame_end) begin
                frame_any  <= 1'b0;
                frame_code <= 4'h0;
            end else if (sample && col_hit && !frame_any) begin
                frame_any  <= 1'b1;
                frame_code <= {col, low_row};
            end
        end
    end

    // Debounce FSM state register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            cand  <= 4'h0;
            cnt   <= 4'h0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
        end
    end

    assign cnt_inc = cnt + 4'd1;

    // Debounce FSM next-state: acts only on the completed frame at frame_end.
    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        push    = 1'b0;
        if (frame_end) begin
            unique case (state)
                IDLE: begin
                    if (frame_any) begin
                        cand_n = frame_code;
                        cnt_n  = 4'd1;
                        if (DEB_FRAMES == 1) begin
                            push    = 1'b1;
                            state_n = HELD;
                        end else begin
                            state_n = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (frame_any && frame_code == cand) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == 4'(DEB_FRAMES)) begin
                            push    = 1'b1;
                            state_n = HELD;
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
                HELD: begin
                    if (!frame_any) begin
                        if (DEB_FRAMES == 1) begin
                            state_n = IDLE;
                        end else begin
                            cnt_n   = 4'd1;
                            state_n = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (frame_any) begin
                        state_n = HELD;
                    end else begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == 4'(DEB_FRAMES)) state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign pop = key_valid && key_ack;

    // Two-entry FIFO: key_code is the head register, ent1 the second entry.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            fcnt      <= 2'd0;
            ent1      <= 4'h0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            case ({push, pop})
                2'b10: begin
                    if (fcnt == 2'd0) begin
                        key_code  <= frame_code;
                        key_valid <= 1'b1;
                        fcnt      <= 2'd1;
                    end else if (fcnt == 2'd1) begin
                        ent1 <= frame_code;
                        fcnt <= 2'd2;
                    end else begin
                        overflow <= 1'b1;
                    end
                end
                2'b01: begin
                    if (fcnt == 2'd2) begin
                        key_code <= ent1;
                        fcnt     <= 2'd1;
                    end else begin
                        key_valid <= 1'b0;
                        fcnt      <= 2'd0;
                    end
                end
                2'b11: begin
                    if (fcnt == 2'd2) begin
                        key_code <= ent1;
                        ent1     <= frame_code;
                    end else begin
                        key_code <= frame_code;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEB_FRAMES=3 (16-cycle frames).
// A frame_end strobe falls on every cycle index that is a nonzero multiple of 16
// counted from reset release; pushes show up on key_valid one cycle later.
module tb_keypad_scanner;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ack;
    logic        overflow;

    logic [15:0] pressed;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    bit          vld_seen;
    int          ovf_total;

    keypad_scanner #(.SCAN_DIV(4), .DEB_FRAMES(3)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ack   (key_ack),
        .overflow  (overflow)
    );

    always #5 Clock = ~Clock;

    // Cycle index since reset release.
    always @(posedge Clock) cyc <= Reset ? 0 : cyc + 1;

    // Keypad matrix model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[c*4+r] && !col_n[c]) row_n[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance to the negedge of cycle n, noting any key_valid / overflow on the way.
    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(negedge Clock);
            if (key_valid === 1'b1) vld_seen = 1'b1;
            if (overflow === 1'b1) ovf_total++;
        end
    endtask

    task automatic do_reset();
        Reset   = 1'b1;
        pressed = 16'h0;
        key_ack = 1'b0;
        @(posedge Clock);
        @(posedge Clock);
        @(negedge Clock);
        Reset     = 1'b0;
        vld_seen  = 1'b0;
        ovf_total = 0;
    endtask

    // Press for three frames, then release and let the release debounce finish.
    task automatic press_cycle(input int base, input int code);
        wait_cyc(base);
        pressed = 16'h0;
        pressed[code] = 1'b1;
        wait_cyc(base + 48);
        pressed = 16'h0;
    endtask

    initial begin
        logic [3:0] e;
        Reset   = 1'b1;
        pressed = 16'h0;
        key_ack = 1'b0;
        vld_seen  = 1'b0;
        ovf_total = 0;

        // 1: reset values and column stepping
        @(posedge Clock);
        @(negedge Clock);
        chk("rst_col_n", col_n, 4'b1110);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_code", key_code, 4'h0);
        chk("rst_ovf", overflow, 1'b0);
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        for (int k = 0; k <= 16; k += 2) begin
            wait_cyc(k);
            e = 4'b1111 ^ (4'b0001 << ((k / 4) % 4));
            chk($sformatf("col_step_%0d", k), col_n, e);
        end

        // 2: held key 6 gives exactly one entry
        do_reset();
        pressed[6] = 1'b1;
        wait_cyc(48);
        chk("t2_valid_pre", key_valid, 1'b0);
        wait_cyc(49);
        chk("t2_valid", key_valid, 1'b1);
        chk("t2_code", key_code, 4'd6);
        wait_cyc(60);
        chk("t2_code_hold", key_code, 4'd6);
        key_ack = 1'b1;
        wait_cyc(61);
        key_ack = 1'b0;
        chk("t2_popped", key_valid, 1'b0);
        vld_seen = 1'b0;
        wait_cyc(96);
        pressed = 16'h0;
        wait_cyc(150);
        chk("t2_no_second", vld_seen, 1'b0);
        chk("t2_no_ovf", ovf_total, 0);

        // 3: bounce shorter than DEB_FRAMES never accepted
        do_reset();
        pressed[6] = 1'b1;
        wait_cyc(16);
        pressed = 16'h0;
        wait_cyc(32);
        pressed[6] = 1'b1;
        wait_cyc(64);
        pressed = 16'h0;
        wait_cyc(140);
        chk("t3_no_valid", vld_seen, 1'b0);

        // 4: two keys together -> lowest code only
        do_reset();
        pressed[1] = 1'b1;
        pressed[9] = 1'b1;
        wait_cyc(49);
        chk("t4_valid", key_valid, 1'b1);
        chk("t4_code", key_code, 4'd1);
        wait_cyc(64);
        pressed = 16'h0;
        wait_cyc(70);
        key_ack = 1'b1;
        wait_cyc(71);
        key_ack = 1'b0;
        chk("t4_single", key_valid, 1'b0);
        vld_seen = 1'b0;
        wait_cyc(130);
        chk("t4_no_more", vld_seen, 1'b0);

        // 5a: third push into a full FIFO overflows
        do_reset();
        press_cycle(0, 3);
        press_cycle(96, 5);
        press_cycle(192, 7);
        wait_cyc(241);
        chk("t5_ovf_pulse", overflow, 1'b1);
        wait_cyc(242);
        chk("t5_ovf_end", overflow, 1'b0);
        wait_cyc(250);
        chk("t5_ovf_count", ovf_total, 1);
        chk("t5_head3", key_code, 4'd3);
        key_ack = 1'b1;
        wait_cyc(251);
        key_ack = 1'b0;
        chk("t5_valid5", key_valid, 1'b1);
        chk("t5_head5", key_code, 4'd5);
        wait_cyc(252);
        key_ack = 1'b1;
        wait_cyc(253);
        key_ack = 1'b0;
        chk("t5_empty", key_valid, 1'b0);

        // 5b: ack on the push-7 cycle -> no overflow, FIFO holds 5 then 7
        do_reset();
        press_cycle(0, 3);
        press_cycle(96, 5);
        wait_cyc(192);
        pressed[7] = 1'b1;
        wait_cyc(240);
        pressed = 16'h0;
        key_ack = 1'b1;
        wait_cyc(241);
        key_ack = 1'b0;
        chk("t5b_no_ovf", overflow, 1'b0);
        chk("t5b_head5", key_code, 4'd5);
        wait_cyc(245);
        chk("t5b_ovf_count", ovf_total, 0);
        key_ack = 1'b1;
        wait_cyc(246);
        chk("t5b_head7", key_code, 4'd7);
        chk("t5b_valid7", key_valid, 1'b1);
        wait_cyc(247);
        key_ack = 1'b0;
        chk("t5b_empty", key_valid, 1'b0);

        // 6: reset mid-debounce restarts the full debounce
        do_reset();
        pressed[10] = 1'b1;
        wait_cyc(33);
        Reset = 1'b1;
        @(negedge Clock);
        Reset    = 1'b0;
        vld_seen = 1'b0;
        chk("t6_cyc_restart", cyc, 0);
        wait_cyc(48);
        chk("t6_no_early", vld_seen, 1'b0);
        wait_cyc(49);
        chk("t6_valid", key_valid, 1'b1);
        chk("t6_code", key_code, 4'd10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad, synchronises and debounces the row inputs, and encodes each accepted key press as a 4-bit key code. Accepted codes are queued in a 2-entry FIFO and presented through a valid/ack handshake. The block sits directly upstream of the calculator core's input interface: a small encoder maps `key_code` to the core's input command, and the core's `in_ack` drives `key_ack`.

## Interface
- `SCAN_DIV`, default 1000: clock cycles per column slot; must be at least 4.
- `DEB_FRAMES`, default 4: number of consecutive identical frames needed to accept a press or a release; range 1..15.

- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  reset, synchronous and active-high.
- `row_n`  in  4  keypad rows, active-low, externally pulled up; asynchronous to `Clock`.
- `col_n`  out  4  column drive, active-low, exactly one bit low at a time.
- `key_valid`  out  1  FIFO head holds a code.
- `key_code`  out  4  FIFO head code: `col*4 + row`.
- `key_ack`  in  1  consumer accepts the head this cycle; ignored while `key_valid`=0.
- `overflow`  out  1  one-cycle pulse when an accepted press is dropped because the FIFO is full.

## Operation
- Synchroniser: `row_n` passes through 2 flops before use.
- Scan:
  - Slot counter runs 0..SCAN_DIV-1; column counter `col` runs 0..3 and wraps.
  - `col_n = ~(4'b1 << col)`.
  - The synchronised rows are sampled when slot = SCAN_DIV-1, which leaves at least 3 cycles of settling.
- Frame: one pass over columns 0..3, i.e. 4*SCAN_DIV cycles.
  - A frame records the lowest-index pressed key (`col*4 + row`, lowest row within a column, lowest column first) and an any-pressed flag.
  - `frame_end` strobes the cycle after the column-3 sample. The FSM evaluates the completed frame on that cycle and then clears the frame record.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE. `cand` is the candidate code; `cnt` is the 4-bit frame counter. Transitions occur only on `frame_end`:
  - IDLE:
    - Any key pressed: `cand` = lowest code, `cnt` = 1, go to DEBOUNCE.
    - Otherwise stay.
  - DEBOUNCE:
    - Lowest code == `cand`: `cnt`++. When `cnt` reaches DEB_FRAMES, push `cand` and go to HELD.
    - Different key or no key: go to IDLE.
    - With DEB_FRAMES=1 the push happens on the IDLE->DEBOUNCE frame and the FSM goes straight to HELD.
  - HELD:
    - No key: `cnt` = 1, go to RELEASE. If DEB_FRAMES=1, go directly to IDLE.
    - Otherwise stay. Auto-repeat is not supported, and changing key while held is ignored.
  - RELEASE:
    - No key: `cnt`++. When it reaches DEB_FRAMES, go to IDLE.
    - Any key: go to HELD.
- FIFO, 2 entries:
  - Pop when `key_valid && key_ack`.
  - Push when the FIFO is full and there is no pop in the same cycle: the code is dropped and `overflow` pulses.
  - Push and pop in the same cycle while full: both happen, no overflow.
  - Push and pop in the same cycle with one entry: the count stays 1 and the new code becomes the head.
  - Push while empty: `key_valid` and `key_code` update on the next edge.

## Timing
- Reset values: `col_n`=4'b1110, `key_valid`=0, `key_code`=4'h0, `overflow`=0. Internally: FSM in IDLE, FIFO empty, counters 0, frame record cleared, synchroniser flops at 4'b1111.
- Reset mid-operation discards any debounce in progress and any queued codes. A key still held after reset must be re-debounced for the full DEB_FRAMES frames.
- All outputs are registered.
- Push takes effect on the `frame_end` edge; `key_valid` rises 1 cycle after the `frame_end` strobe.
- Latency from a stable press to `key_valid`: at most (DEB_FRAMES+1)*4*SCAN_DIV + 4 cycles.
- `key_code` holds stable while `key_valid`=1 and no ack. After a pop, the next entry (if any) appears on the following cycle with no bubble.
- `overflow` is high for exactly one cycle per dropped code.

## Test plan
Bench settings: SCAN_DIV=4, DEB_FRAMES=3 (16-cycle frame).
1. Assert Reset for 2 cycles -> `col_n`=1110, `key_valid`=0, `key_code`=0, `overflow`=0. After release, `col_n` steps 1110->1101->1011->0111 every 4 cycles, then wraps.
2. Hold col 1 / row 2 for 6 frames, keep `key_ack`=0 -> exactly one entry, `key_code`=6, `key_valid` rises 1 cycle after the 3rd `frame_end`. Pulse `key_ack` for 1 cycle -> `key_valid`=0 next cycle; no second entry while the key stays held.
3. Press code 6 for 1 frame, release for 1 frame, press for 2 frames, release -> `key_valid` stays 0 throughout.
4. Hold codes 1 and 9 simultaneously for 4 frames -> a single entry, `key_code`=1.
5. With `key_ack`=0, do three debounced press/release cycles of codes 3, 5, 7 -> `overflow` pulses once, at the push of 7. Acks then yield 3, then 5, then `key_valid`=0. Repeat the test with an ack landing on the cycle of push 7 -> no overflow, and the FIFO ends holding 5 then 7.
6. Hold code 10; assert Reset in the cycle after the 2nd `frame_end`, keep holding -> `key_valid` stays 0 until the 3rd post-reset `frame_end`, then `key_code`=10.
